spi_sclk_gen: RTL and testbench
===============================

SPI_SCLK_GEN -- requirements
Module: spi_sclk_gen

Interface
REQ-001 Parameter DIV_W, default 16, divider width.
REQ-002 Parameter LEN_W, default 6, transfer-length (bit count) width.
REQ-003 clk_i  input  1  system clock, all logic on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 cfg_cpol_i  input  1  SCLK idle level.
REQ-006 cfg_cpha_i  input  1  clock phase: 0 sample on leading edge, 1 shift on leading edge.
REQ-007 clk_div_i  input  DIV_W  SCLK period in clk_i cycles.
REQ-008 xfer_len_i  input  LEN_W  bits in transfer.
REQ-009 start_i  input  1  start request, one-cycle pulse.
REQ-010 abort_i  input  1  terminate transfer.
REQ-011 sclk_o  output  1  SPI clock, registered.
REQ-012 sample_o  output  1  one-cycle pulse: receive data sample point.
REQ-013 shift_o  output  1  one-cycle pulse: transmit data shift point.
REQ-014 busy_o  output  1  transfer in progress.
REQ-015 done_o  output  1  one-cycle pulse: transfer completed normally.

Function
REQ-016 FSM states IDLE, LEAD, RUN; IDLE->LEAD (or RUN when LEAD compiled out) on start_i; RUN->IDLE after final edge or on abort_i; any->IDLE on abort_i.
REQ-017 start_i accepted only in IDLE; cfg_cpol_i, cfg_cpha_i, clk_div_i, xfer_len_i latched on acceptance; start_i while busy_o=1 ignored.
REQ-018 busy_o high the cycle after acceptance until the cycle after the final edge or abort.
REQ-019 Effective divider D = max(clk_div_i,2); high half-period ceil(D/2) cycles, low half-period floor(D/2) cycles (odd divisors supported, unlike even-only halving).
REQ-020 Half-period counter restarts at 0 on acceptance; at terminal count an edge event occurs: sclk_o toggles on the next clk_i edge, and sample_o/shift_o pulse in the terminal-count cycle.
REQ-021 Exactly 2*xfer_len_i edges per transfer; odd-numbered edges leading, even-numbered trailing.
REQ-022 CPHA=0: sample_o on every leading edge; shift_o on every trailing edge except the last.
REQ-023 CPHA=1: shift_o on every leading edge; sample_o on every trailing edge.
REQ-024 done_o pulses in the cycle the final edge is issued; sclk_o ends at latched CPOL.
REQ-025 xfer_len_i=0: no edges, no sample/shift, done_o pulses the cycle after acceptance.
REQ-026 abort_i: next cycle IDLE, sclk_o=cfg CPOL, busy_o=0, no done_o, no further pulses; abort_i has priority over simultaneous final edge.
REQ-027 In IDLE sclk_o tracks cfg_cpol_i with one-cycle latency; sample_o, shift_o, done_o low.
REQ-028 Counter and edge count widths sized to DIV_W and LEN_W+1; no wrap within a legal transfer.

Reset
REQ-029 rst_i high: state IDLE, counters 0, sclk_o=0, sample_o=shift_o=busy_o=done_o=0, latched config 0.
REQ-030 rst_i mid-transfer aborts it identically; no done_o generated.

Configuration
REQ-031 Macro SPI_SCLK_GEN_LEAD_EN defined: LEAD state inserts one low-half-period (floor(D/2) cycles) before first edge for CS setup, busy_o high throughout.
REQ-032 SPI_SCLK_GEN_LEAD_EN undefined: LEAD state absent, first edge floor(D/2) cycles after acceptance counting from counter restart.

Structure
REQ-033 Shared package spi_pkg: FSM state enum, default DIV_W/LEN_W constants, minimum-divider constant 2.
REQ-034 One sub-module spi_half_period_cnt: loadable down/up counter emitting terminal-count pulse given high/low period.

Verification
REQ-035 CPOL=0, CPHA=0, div=4, len=8: 16 edges, 2-cycle half-periods, 8 sample_o on rising, 7 shift_o on falling, one done_o, sclk_o ends 0.
REQ-036 CPOL=1, CPHA=1, div=5, len=3: high 3 cycles, low 2, 3 shift_o on falling, 3 sample_o on rising, sclk_o idle 1.
REQ-037 div=0 and div=1: behave as div=2, SCLK period 2 cycles.
REQ-038 len=0: done_o one cycle after start, sclk_o never toggles.
REQ-039 abort_i at 5th edge, len=8: busy_o low next cycle, no done_o, sclk_o returns to CPOL; start_i issued mid-transfer ignored.
REQ-040 rst_i asserted during RUN then new start with LEAD_EN defined and undefined: first-edge latency matches REQ-031/REQ-032.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI serial-clock generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LEAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam int DEF_DIV_W = 16;
    localparam int DEF_LEN_W = 6;
    localparam int MIN_DIV   = 2;
endpackage

// File: rtl/spi_sclk_gen_if.sv
// Control/config/status bundle between an SPI controller and the SCLK generator.
// Latency: n/a (wiring only).
// Backpressure: none; start_i is a single-cycle request ignored while busy_o is high.
interface spi_sclk_gen_if #(
    parameter int DIV_W = 16,
    parameter int LEN_W = 6
);
    logic             cfg_cpol_i;
    logic             cfg_cpha_i;
    logic [DIV_W-1:0] clk_div_i;
    logic [LEN_W-1:0] xfer_len_i;
    logic             start_i;
    logic             abort_i;
    logic             sclk_o;
    logic             sample_o;
    logic             shift_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        output cfg_cpol_i, cfg_cpha_i, clk_div_i, xfer_len_i, start_i, abort_i,
        input  sclk_o, sample_o, shift_o, busy_o, done_o
    );

    modport slave (
        input  cfg_cpol_i, cfg_cpha_i, clk_div_i, xfer_len_i, start_i, abort_i,
        output sclk_o, sample_o, shift_o, busy_o, done_o
    );
endinterface

// File: rtl/spi_half_period_cnt.sv
// Loadable up counter that flags the last cycle of a programmable half period.
// Latency: tc_o is combinational from the registered count; count restarts after tc.
// Backpressure: none; holds at zero while disabled.
module spi_half_period_cnt #(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] period_i,
    output logic             tc_o
);
    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] r_cnt;

    assign tc_o = en_i && (r_cnt == period_i - ONE);

    always_ff @(posedge clk_i) begin
        if (rst_i || load_i || !en_i || tc_o) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + ONE;
        end
    end
endmodule

// File: rtl/spi_sclk_gen.sv
// SPI SCLK generator with CPOL/CPHA sample/shift strobes; SPI_SCLK_GEN_LEAD_EN adds a CS-setup lead-in.
// Latency: first edge strobe floor(D/2) cycles after start (plus floor(D/2) with lead-in).
// Backpressure: start_i ignored while busy; abort_i returns to idle next cycle.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic          clk_i,
    input  logic          rst_i,
    spi_sclk_gen_if.slave bus
);
    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_cpol;
    logic             r_cpha;
    logic [DIV_W-1:0] r_div;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W:0]   r_edge_cnt;
    logic             r_sclk;

    logic [DIV_W-1:0] w_div_eff;
    logic [DIV_W-1:0] w_hi;
    logic [DIV_W-1:0] w_lo;
    logic [DIV_W-1:0] w_period;
    logic [LEN_W:0]   w_edge_nxt;
    logic             w_tc;
    logic             w_sel_hi;
    logic             w_final;
    logic             w_leading;
    logic             w_accept;
    logic             w_edge;
    logic             w_sample;
    logic             w_shift;
    logic             w_done;

    assign w_div_eff  = (r_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : r_div;
    assign w_lo       = w_div_eff >> 1;
    assign w_hi       = w_div_eff - w_lo;
    assign w_edge_nxt = r_edge_cnt + {{LEN_W{1'b0}}, 1'b1};
    assign w_final    = (w_edge_nxt == {r_len, 1'b0});
    assign w_leading  = ~r_edge_cnt[0];

    // The wait before the first edge is always the short half; later halves follow the SCLK level.
    assign w_sel_hi = (r_state == ST_RUN) && (r_edge_cnt != '0) && r_sclk;
    assign w_period = w_sel_hi ? w_hi : w_lo;

    spi_half_period_cnt #(.DIV_W(DIV_W)) u_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (w_accept),
        .en_i     (r_state != ST_IDLE),
        .period_i (w_period),
        .tc_o     (w_tc)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_edge      = 1'b0;
        w_sample    = 1'b0;
        w_shift     = 1'b0;
        w_done      = 1'b0;
        if (!rst_i) begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start_i && !bus.abort_i) begin
                        w_accept = 1'b1;
`ifdef SPI_SCLK_GEN_LEAD_EN
                        w_state_nxt = ST_LEAD;
`else
                        w_state_nxt = ST_RUN;
`endif
                    end
                end
`ifdef SPI_SCLK_GEN_LEAD_EN
                ST_LEAD: begin
                    if (bus.abort_i) begin
                        w_state_nxt = ST_IDLE;
                    end else if (r_len == '0) begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (w_tc) begin
                        w_state_nxt = ST_RUN;
                    end
                end
`endif
                ST_RUN: begin
                    if (bus.abort_i) begin
                        w_state_nxt = ST_IDLE;
                    end else if (r_len == '0) begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (w_tc) begin
                        w_edge   = 1'b1;
                        w_sample = r_cpha ? !w_leading : w_leading;
                        w_shift  = r_cpha ? w_leading : (!w_leading && !w_final);
                        if (w_final) begin
                            w_done      = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sclk     <= 1'b0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_div      <= '0;
            r_len      <= '0;
            r_edge_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_cpol     <= bus.cfg_cpol_i;
                r_cpha     <= bus.cfg_cpha_i;
                r_div      <= bus.clk_div_i;
                r_len      <= bus.xfer_len_i;
                r_edge_cnt <= '0;
            end else if (w_edge) begin
                r_edge_cnt <= w_edge_nxt;
            end
            if (r_state == ST_IDLE || bus.abort_i) begin
                r_sclk <= bus.cfg_cpol_i;
            end else if (w_edge) begin
                r_sclk <= w_final ? r_cpol : ~r_sclk;
            end
        end
    end

    assign bus.sclk_o   = r_sclk;
    assign bus.sample_o = w_sample;
    assign bus.shift_o  = w_shift;
    assign bus.done_o   = w_done;
    assign bus.busy_o   = (r_state != ST_IDLE) && !rst_i;
endmodule

// File: tb/tb_spi_sclk_gen.sv
// Directed bench for spi_sclk_gen; expectations are hand-derived cycle numbers
// relative to the start-acceptance cycle (cycle 0), adjusted for the optional lead-in.
module tb_spi_sclk_gen;
    import spi_pkg::*;

    localparam int DIV_W = DEF_DIV_W;
    localparam int LEN_W = DEF_LEN_W;
`ifdef SPI_SCLK_GEN_LEAD_EN
    localparam int L = 1;
`else
    localparam int L = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_sclk_gen_if #(.DIV_W(DIV_W), .LEN_W(LEN_W)) bus ();

    spi_sclk_gen #(.DIV_W(DIV_W), .LEN_W(LEN_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    bit a_sclk  [0:199];
    bit a_samp  [0:199];
    bit a_shift [0:199];
    bit a_done  [0:199];
    bit a_busy  [0:199];
    int tog_c   [0:63];
    int n_tog, n_samp, n_samp_lo, n_shift, n_shift_hi, n_done, done_c;
    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic setcfg(input bit cpol, input bit cpha, input int div, input int len);
        bus.cfg_cpol_i = cpol;
        bus.cfg_cpha_i = cpha;
        bus.clk_div_i  = DIV_W'(div);
        bus.xfer_len_i = LEN_W'(len);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic analyze(input int n);
        n_tog = 0; n_samp = 0; n_samp_lo = 0; n_shift = 0; n_shift_hi = 0;
        n_done = 0; done_c = -1;
        for (int i = 0; i < 64; i++) tog_c[i] = -1;
        for (int c = 0; c < n; c++) begin
            if (c > 0 && a_sclk[c] != a_sclk[c-1]) begin
                if (n_tog < 64) tog_c[n_tog] = c;
                n_tog++;
            end
            if (a_samp[c]) begin
                n_samp++;
                if (!a_sclk[c]) n_samp_lo++;
            end
            if (a_shift[c]) begin
                n_shift++;
                if (a_sclk[c]) n_shift_hi++;
            end
            if (a_done[c]) begin
                n_done++;
                if (done_c < 0) done_c = c;
            end
        end
    endtask

    // Cycle 0 carries start_i; optional mid-run start/abort/reset at given cycles (-1 = never).
    task automatic run(input int ncyc, input int abort_at, input int start_at, input int rst_at);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            bus.start_i = (c == 0) || (c == start_at);
            if (c == start_at) bus.xfer_len_i = LEN_W'(1);
            bus.abort_i = (c == abort_at);
            rst         = (c == rst_at);
            @(negedge clk);
            a_sclk[c]  = bus.sclk_o;
            a_samp[c]  = bus.sample_o;
            a_shift[c] = bus.shift_o;
            a_done[c]  = bus.done_o;
            a_busy[c]  = bus.busy_o;
        end
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        rst         = 1'b0;
        analyze(ncyc);
    endtask

    initial begin
        bus.cfg_cpol_i = 1'b1;
        bus.cfg_cpha_i = 1'b0;
        bus.clk_div_i  = DIV_W'(4);
        bus.xfer_len_i = LEN_W'(8);
        bus.start_i    = 1'b1;
        bus.abort_i    = 1'b0;

        // Reset dominates a pending start and a high CPOL request
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sclk",   int'(bus.sclk_o),   0);
        chk("rst_busy",   int'(bus.busy_o),   0);
        chk("rst_done",   int'(bus.done_o),   0);
        chk("rst_sample", int'(bus.sample_o), 0);
        chk("rst_shift",  int'(bus.shift_o),  0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.start_i = 1'b0;
        @(negedge clk);
        chk("idle_cpol_lat0", int'(bus.sclk_o), 0);
        @(negedge clk);
        chk("idle_cpol_lat1", int'(bus.sclk_o), 1);

        // CPOL0 CPHA0 div4 len8
        setcfg(0, 0, 4, 8);
        run(45, -1, -1, -1);
        chk("t1_edges",      n_tog, 16);
        chk("t1_first_edge", tog_c[0], 3 + 2*L);
        chk("t1_half_a",     tog_c[1] - tog_c[0], 2);
        chk("t1_half_b",     tog_c[2] - tog_c[1], 2);
        chk("t1_last_edge",  tog_c[15], 33 + 2*L);
        chk("t1_samples",    n_samp, 8);
        chk("t1_samp_rise",  n_samp_lo, 8);
        chk("t1_shifts",     n_shift, 7);
        chk("t1_shift_fall", n_shift_hi, 7);
        chk("t1_done_cnt",   n_done, 1);
        chk("t1_done_cyc",   done_c, 32 + 2*L);
        chk("t1_busy_c0",    int'(a_busy[0]), 0);
        chk("t1_busy_c1",    int'(a_busy[1]), 1);
        chk("t1_busy_done",  int'(a_busy[32 + 2*L]), 1);
        chk("t1_busy_after", int'(a_busy[33 + 2*L]), 0);
        chk("t1_sclk_end",   int'(a_sclk[44]), 0);

        // CPOL1 CPHA1 div5 len3: high 3, low 2
        setcfg(1, 1, 5, 3);
        run(25, -1, -1, -1);
        chk("t2_idle_hi",    int'(a_sclk[0]), 1);
        chk("t2_edges",      n_tog, 6);
        chk("t2_first_edge", tog_c[0], 3 + 2*L);
        chk("t2_high_len",   tog_c[2] - tog_c[1], 3);
        chk("t2_low_len",    tog_c[3] - tog_c[2], 2);
        chk("t2_shift_fall", n_shift_hi, 3);
        chk("t2_shifts",     n_shift, 3);
        chk("t2_samp_rise",  n_samp_lo, 3);
        chk("t2_samples",    n_samp, 3);
        chk("t2_done_cyc",   done_c, 14 + 2*L);
        chk("t2_sclk_end",   int'(a_sclk[24]), 1);

        // div 0 and 1 clamp to 2
        setcfg(0, 0, 0, 2);
        run(12, -1, -1, -1);
        chk("d0_edges",  n_tog, 4);
        chk("d0_first",  tog_c[0], 2 + L);
        chk("d0_period", tog_c[2] - tog_c[0], 2);
        chk("d0_done",   done_c, 4 + L);
        setcfg(0, 0, 1, 2);
        run(12, -1, -1, -1);
        chk("d1_edges",  n_tog, 4);
        chk("d1_first",  tog_c[0], 2 + L);
        chk("d1_period", tog_c[2] - tog_c[0], 2);
        chk("d1_done",   done_c, 4 + L);

        // Zero-length transfer
        setcfg(0, 0, 4, 0);
        run(10, -1, -1, -1);
        chk("l0_done_cyc", done_c, 1);
        chk("l0_done_cnt", n_done, 1);
        chk("l0_edges",    n_tog, 0);
        chk("l0_pulses",   n_samp + n_shift, 0);
        chk("l0_busy_c1",  int'(a_busy[1]), 1);
        chk("l0_busy_c2",  int'(a_busy[2]), 0);

        // Abort just after the 5th edge; a mid-transfer start must be ignored
        setcfg(0, 0, 4, 8);
        run(30, 11 + 2*L, 6, -1);
        chk("ab_5th_edge", tog_c[4], 11 + 2*L);
        chk("ab_return",   tog_c[5], 12 + 2*L);
        chk("ab_edges",    n_tog, 6);
        chk("ab_samples",  n_samp, 3);
        chk("ab_shifts",   n_shift, 2);
        chk("ab_done",     n_done, 0);
        chk("ab_busy",     int'(a_busy[12 + 2*L]), 0);
        chk("ab_sclk_end", int'(a_sclk[29]), 0);

        // Abort coinciding with the final edge wins over done
        setcfg(0, 0, 2, 1);
        run(10, 2 + L, -1, -1);
        chk("pr_done",    n_done, 0);
        chk("pr_samples", n_samp, 1);
        chk("pr_busy",    int'(a_busy[3 + L]), 0);

        // Reset mid-transfer, then a fresh transfer
        setcfg(0, 0, 4, 8);
        run(20, -1, -1, 6);
        chk("rm_done",    n_done, 0);
        chk("rm_busy_c5", int'(a_busy[5]), 1);
        chk("rm_busy_c7", int'(a_busy[7]), 0);
        chk("rm_busy_end", int'(a_busy[19]), 0);
        setcfg(0, 0, 4, 8);
        run(10, -1, -1, -1);
        chk("rm_first_edge", tog_c[0], 3 + 2*L);
        chk("rm_busy_c1",    int'(a_busy[1]), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
